csc_weight_encoder: RTL and testbench

- Streaming compressed-sparse-column (CSC) encoder. Writes into a PE's weight data spad and weight address spad.
- Accepts a dense weight matrix column-by-column, one element per handshake.
- Emits a data stream of {value,row index} for every nonzero element.
- Emits an address stream with one cumulative end-pointer per column, followed by a zero end-sign. This is the exact write-side format the address spad consumes: it stops writing on a zero and reserves 127.

---
 rtl/csc_weight_encoder_if.sv | 44 ++++
 rtl/csc_weight_encoder.sv | 168 ++++++++++++++++
 tb/tb_csc_weight_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csc_weight_encoder_if.sv
// ----------------------------------------------------------------------------
// csc_weight_encoder_if
// Handshake bundle for the CSC weight encoder.
//   Dense input  : in_valid/in_ready, in_data, in_col_last, in_mat_last
//   Data stream  : data_out_valid/data_out_ready, data_out = {value, row}
//   Addr stream  : addr_out_valid/addr_out_ready, addr_out, addr_out_last
//   Status       : done (end-sign accepted pulse), overflow (sticky)
// slave  : the encoder side.
// master : the producer/consumer side driving the encoder.
// ----------------------------------------------------------------------------
interface csc_weight_encoder_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 4,
    parameter int ADDR_W = 7
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_col_last;
    logic                    in_mat_last;
    logic                    data_out_valid;
    logic                    data_out_ready;
    logic [DATA_W+ROW_W-1:0] data_out;
    logic                    addr_out_valid;
    logic                    addr_out_ready;
    logic [ADDR_W-1:0]       addr_out;
    logic                    addr_out_last;
    logic                    done;
    logic                    overflow;

    modport slave (
        input  in_valid, in_data, in_col_last, in_mat_last,
        input  data_out_ready, addr_out_ready,
        output in_ready, data_out_valid, data_out,
        output addr_out_valid, addr_out, addr_out_last, done, overflow
    );

    modport master (
        output in_valid, in_data, in_col_last, in_mat_last,
        output data_out_ready, addr_out_ready,
        input  in_ready, data_out_valid, data_out,
        input  addr_out_valid, addr_out, addr_out_last, done, overflow
    );
endinterface

// File: rtl/csc_weight_encoder.sv
// ----------------------------------------------------------------------------
// csc_weight_encoder
// Streaming dense-to-CSC encoder feeding a PE's weight data and address spads.
// Dense weights arrive column by column; every nonzero emits {value, row} on
// the data stream, every column end emits a cumulative end-pointer (or
// EMPTY_CODE for an all-zero column) on the address stream, and the matrix is
// closed by a 0 end-sign qualified with addr_out_last.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : csc_weight_encoder_if.slave (input, data, addr streams,
//                  done pulse and sticky overflow)
// ----------------------------------------------------------------------------
module csc_weight_encoder #(
    parameter int DATA_W     = 8,
    parameter int ROW_W      = 4,
    parameter int ADDR_W     = 7,
    parameter int EMPTY_CODE = 127,
    parameter int MAX_NZ     = 126
) (
    input  logic                 clock,
    input  logic                 reset,
    csc_weight_encoder_if.slave  bus
);

    typedef enum logic [1:0] {RUN, TERM, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0]       nz_cnt_q, nz_cnt_d;
    logic                    col_nz_q, col_nz_d;
    logic                    data_valid_q, data_valid_d;
    logic [DATA_W+ROW_W-1:0] data_q, data_d;
    logic                    addr_valid_q, addr_valid_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    addr_last_q, addr_last_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic data_free;
    logic addr_free;
    logic in_ready;
    logic accept;
    logic col_last;
    logic elem_nz;
    logic take_nz;
    logic end_hs;

    // A slot is free if empty or being drained in this same cycle.
    assign data_free = !data_valid_q || bus.data_out_ready;
    assign addr_free = !addr_valid_q || bus.addr_out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign col_last  = bus.in_col_last || bus.in_mat_last;
    assign elem_nz   = (bus.in_data != '0);
    assign take_nz   = accept && elem_nz && (nz_cnt_q < ADDR_W'(MAX_NZ));
    assign end_hs    = addr_valid_q && bus.addr_out_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && bus.in_mat_last) state_d = TERM;
            TERM:    if (addr_free)                 state_d = WAIT;
            WAIT:    if (end_hs)                    state_d = RUN;
            default:                                state_d = RUN;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready = !reset && (state_q == RUN) && data_free && addr_free;
    end

    assign bus.in_ready       = in_ready;
    assign bus.data_out_valid = data_valid_q;
    assign bus.data_out       = data_q;
    assign bus.addr_out_valid = addr_valid_q;
    assign bus.addr_out       = addr_q;
    assign bus.addr_out_last  = addr_last_q;
    assign bus.done           = done_q;
    assign bus.overflow       = ovf_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        row_cnt_d    = row_cnt_q;
        nz_cnt_d     = nz_cnt_q;
        col_nz_d     = col_nz_q;
        data_valid_d = data_valid_q;
        data_d       = data_q;
        addr_valid_d = addr_valid_q;
        addr_d       = addr_q;
        addr_last_d  = addr_last_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;

        if (bus.data_out_ready) data_valid_d = 1'b0;
        if (bus.addr_out_ready) addr_valid_d = 1'b0;

        if (accept) begin
            row_cnt_d = col_last ? '0 : row_cnt_q + ROW_W'(1);
            if (elem_nz && !take_nz) ovf_d = 1'b1;
        end

        if (take_nz) begin
            nz_cnt_d     = nz_cnt_q + ADDR_W'(1);
            col_nz_d     = 1'b1;
            data_valid_d = 1'b1;
            data_d       = {bus.in_data, row_cnt_q};
        end

        // End-pointer uses the count including the current element.
        if (accept && col_last) begin
            addr_valid_d = 1'b1;
            addr_d       = (col_nz_q || take_nz) ? nz_cnt_d : ADDR_W'(EMPTY_CODE);
            addr_last_d  = 1'b0;
            col_nz_d     = 1'b0;
        end

        if ((state_q == TERM) && addr_free) begin
            addr_valid_d = 1'b1;
            addr_d       = '0;
            addr_last_d  = 1'b1;
        end

        if ((state_q == WAIT) && end_hs) begin
            done_d      = 1'b1;
            nz_cnt_d    = '0;
            row_cnt_d   = '0;
            addr_last_d = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt_q    <= '0;
            nz_cnt_q     <= '0;
            col_nz_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            addr_last_q  <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            nz_cnt_q     <= nz_cnt_d;
            col_nz_q     <= col_nz_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            addr_last_q  <= addr_last_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csc_weight_encoder.sv
// ----------------------------------------------------------------------------
// tb_csc_weight_encoder
// Scoreboard bench: expected data/address entries are pushed when an input
// element is accepted and popped when the encoder hands the entry off.
// ----------------------------------------------------------------------------
module tb_csc_weight_encoder;

    logic clock;
    logic reset;

    csc_weight_encoder_if #(.DATA_W(8), .ROW_W(4), .ADDR_W(7)) bus_if ();

    csc_weight_encoder #(
        .DATA_W(8), .ROW_W(4), .ADDR_W(7), .EMPTY_CODE(127), .MAX_NZ(126)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard and reference model
    logic [11:0] exp_data[$];
    logic [7:0]  exp_addr[$];   // {last, addr}
    logic [11:0] obs_data[$];
    logic [7:0]  obs_addr[$];
    logic [3:0]  m_row;
    int unsigned m_nz;
    bit          m_colnz, m_ovf, m_term, pend_done;
    int unsigned done_cnt = 0;
    bit          p_dstall, p_astall;
    logic [11:0] p_data;
    logic [7:0]  p_addr;

    bit          rdy_rand  = 0;
    bit          gaps      = 0;
    bit          stall_arm = 0;
    int unsigned addr_stall = 0;

    // ready driver
    initial begin
        bus_if.data_out_ready = 1'b1;
        bus_if.addr_out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall_arm && bus_if.addr_out_valid) begin
                addr_stall = 5;
                stall_arm  = 0;
            end
            bus_if.data_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (addr_stall > 0) begin
                bus_if.addr_out_ready = 1'b0;
                addr_stall--;
            end else begin
                bus_if.addr_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // monitor / model
    always @(negedge clock) begin
        logic [11:0] e;
        logic [7:0]  ea;
        bit          cl;
        bit          exp_rdy;
        if (reset) begin
            exp_data.delete();
            exp_addr.delete();
            m_row = '0; m_nz = 0; m_colnz = 0; m_ovf = 0; m_term = 0;
            pend_done = 0; p_dstall = 0; p_astall = 0;
        end else begin
            if (p_dstall) begin
                check("data_hold_valid", bus_if.data_out_valid, 1);
                check("data_hold_value", bus_if.data_out, p_data);
            end
            if (p_astall) begin
                check("addr_hold_valid", bus_if.addr_out_valid, 1);
                check("addr_hold_value", {bus_if.addr_out_last, bus_if.addr_out}, p_addr);
            end
            exp_rdy = !m_term && (!bus_if.data_out_valid || bus_if.data_out_ready)
                              && (!bus_if.addr_out_valid || bus_if.addr_out_ready);
            check("in_ready", bus_if.in_ready, exp_rdy);
            if (bus_if.done || pend_done) check("done_pulse", bus_if.done, pend_done);
            if (bus_if.done) done_cnt++;
            pend_done = 0;

            if (bus_if.data_out_valid && bus_if.data_out_ready) begin
                obs_data.push_back(bus_if.data_out);
                if (exp_data.size() == 0) check("data_unexpected", bus_if.data_out_valid, 0);
                else begin
                    e = exp_data.pop_front();
                    check("data_out", bus_if.data_out, e);
                end
            end
            if (bus_if.addr_out_valid && bus_if.addr_out_ready) begin
                obs_addr.push_back({bus_if.addr_out_last, bus_if.addr_out});
                if (exp_addr.size() == 0) check("addr_unexpected", bus_if.addr_out_valid, 0);
                else begin
                    ea = exp_addr.pop_front();
                    check("addr_out", {bus_if.addr_out_last, bus_if.addr_out}, ea);
                end
                if (bus_if.addr_out_last) begin
                    pend_done = 1;
                    m_term = 0; m_nz = 0; m_row = '0;
                end
            end

            if (bus_if.in_valid && bus_if.in_ready) begin
                check("overflow", bus_if.overflow, m_ovf);
                cl = bus_if.in_col_last || bus_if.in_mat_last;
                if (bus_if.in_data != 0) begin
                    if (m_nz < 126) begin
                        exp_data.push_back({bus_if.in_data, m_row});
                        m_nz++;
                        m_colnz = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
                m_row = cl ? 4'd0 : m_row + 4'd1;
                if (cl) begin
                    exp_addr.push_back({1'b0, m_colnz ? 7'(m_nz) : 7'd127});
                    m_colnz = 0;
                end
                if (bus_if.in_mat_last) begin
                    exp_addr.push_back(8'h80);
                    m_term = 1;
                end
            end

            p_dstall = bus_if.data_out_valid && !bus_if.data_out_ready;
            p_astall = bus_if.addr_out_valid && !bus_if.addr_out_ready;
            p_data   = bus_if.data_out;
            p_addr   = {bus_if.addr_out_last, bus_if.addr_out};
        end
    end

    task automatic send(input logic [7:0] d, input bit cl, input bit ml);
        int unsigned n;
        n = 0;
        bus_if.in_valid    = 1'b1;
        bus_if.in_data     = d;
        bus_if.in_col_last = cl;
        bus_if.in_mat_last = ml;
        @(negedge clock);
        while (!bus_if.in_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!bus_if.in_ready) check("accept_timeout", bus_if.in_ready, 1);
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned n;
        n = 0;
        while ((done_cnt < target || exp_data.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("done_count", done_cnt, target);
        check("data_drained", exp_data.size(), 0);
        check("addr_drained", exp_addr.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_addr.delete();
    endtask

    task automatic send_m1();
        send(8'd0, 0, 0); send(8'd5, 0, 0); send(8'd0, 1, 0);
        send(8'd0, 0, 0); send(8'd0, 0, 0); send(8'd0, 1, 0);
        send(8'd3, 0, 0); send(8'd0, 0, 0); send(8'd7, 1, 1);
    endtask

    task automatic check_m1(input string tag);
        check({tag, "_ndata"}, obs_data.size(), 3);
        check({tag, "_naddr"}, obs_addr.size(), 4);
        if (obs_data.size() >= 3) begin
            check({tag, "_d0"}, obs_data[0], 12'h051);
            check({tag, "_d1"}, obs_data[1], 12'h030);
            check({tag, "_d2"}, obs_data[2], 12'h072);
        end
        if (obs_addr.size() >= 4) begin
            check({tag, "_a0"}, obs_addr[0], 8'h01);
            check({tag, "_a1"}, obs_addr[1], 8'h7F);
            check({tag, "_a2"}, obs_addr[2], 8'h03);
            check({tag, "_a3"}, obs_addr[3], 8'h80);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dvalid"}, bus_if.data_out_valid, 0);
        check({tag, "_avalid"}, bus_if.addr_out_valid, 0);
        check({tag, "_data"},   bus_if.data_out, 0);
        check({tag, "_addr"},   bus_if.addr_out, 0);
        check({tag, "_last"},   bus_if.addr_out_last, 0);
        check({tag, "_done"},   bus_if.done, 0);
        check({tag, "_ovf"},    bus_if.overflow, 0);
    endtask

    initial begin
        reset              = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.in_data     = '0;
        bus_if.in_col_last = 1'b0;
        bus_if.in_mat_last = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", bus_if.in_ready, 0);
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 3x3 sparse matrix, readies high
        clear_obs();
        send_m1();
        wait_done(1);
        check_m1("m1");

        // all-zero 2x2
        clear_obs();
        send(8'd0, 0, 0); send(8'd0, 1, 0); send(8'd0, 0, 0); send(8'd0, 1, 1);
        wait_done(2);
        check("z_ndata", obs_data.size(), 0);
        check("z_naddr", obs_addr.size(), 3);
        if (obs_addr.size() >= 3) begin
            check("z_a0", obs_addr[0], 8'h7F);
            check("z_a1", obs_addr[1], 8'h7F);
            check("z_a2", obs_addr[2], 8'h80);
        end

        // first matrix again with a 5-cycle address stall
        clear_obs();
        stall_arm = 1;
        send_m1();
        wait_done(3);
        check_m1("stall");

        // 127 nonzeros in one column
        clear_obs();
        for (int i = 0; i < 127; i++) send(8'(i + 1), i == 126, i == 126);
        wait_done(4);
        check("ovf_ndata", obs_data.size(), 126);
        check("ovf_naddr", obs_addr.size(), 2);
        if (obs_addr.size() >= 2) begin
            check("ovf_a0", obs_addr[0], 8'h7E);
            check("ovf_a1", obs_addr[1], 8'h80);
        end
        check("ovf_sticky", bus_if.overflow, 1);

        // reset mid-column
        send(8'd4, 0, 0);
        send(8'd6, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", bus_if.in_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        clear_obs();
        send(8'd9, 1, 1);
        wait_done(5);
        check("one_naddr", obs_addr.size(), 2);
        check("one_ndata", obs_data.size(), 1);
        if (obs_data.size() >= 1) check("one_d0", obs_data[0], 12'h090);
        if (obs_addr.size() >= 2) begin
            check("one_a0", obs_addr[0], 8'h01);
            check("one_a1", obs_addr[1], 8'h80);
        end

        // random sparse matrices under random backpressure
        rdy_rand = 1;
        gaps     = 1;
        for (int m = 0; m < 200; m++) begin
            int unsigned ncol, nrow;
            ncol = $urandom_range(1, 4);
            nrow = $urandom_range(1, 4);
            for (int c = 0; c < int'(ncol); c++) begin
                for (int r = 0; r < int'(nrow); r++) begin
                    logic [7:0] v;
                    bit lastc, lastm;
                    v     = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(1, 255)) : 8'd0;
                    lastm = (c == int'(ncol) - 1) && (r == int'(nrow) - 1);
                    lastc = (r == int'(nrow) - 1) && (!lastm || $urandom_range(0, 1) == 1);
                    send(v, lastc, lastm);
                end
            end
            wait_done(6 + m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
